// File: rtl/instr_fetch_unit_pkg.sv
// rv_fetch_pkg: shared types and constants for the instruction fetch unit
package rv_fetch_pkg;

    typedef enum logic [1:0] {
        RUN,
        HALT,
        FAULT
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam logic [31:0] ECALL_INSTR = 32'h0000_0073;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if: ROM port, decoded-instruction handshake and redirect request
interface instr_fetch_unit_if;

    logic [31:0] rom_addr;
    logic [31:0] rom_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    modport master (
        output rom_addr, inst_valid, inst_out, inst_pc,
        input  rom_data, inst_ready, redirect_valid, redirect_pc
    );

    modport slave (
        input  rom_addr, inst_valid, inst_out, inst_pc,
        output rom_data, inst_ready, redirect_valid, redirect_pc
    );

endinterface

// File: rtl/instr_fetch_unit_queue.sv
// fetch_queue: two-entry FIFO of {pc, instr} with flush; head reads as zero when empty
module fetch_queue
    import rv_fetch_pkg::*;
(
    input  logic         clk,
    input  logic         reset_n,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t wr_entry,
    output fetch_entry_t rd_entry,
    output logic [1:0]   count
);

    fetch_entry_t [1:0] mem_q, mem_d;
    logic               wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [1:0]         count_q, count_d;

    assign count    = count_q;
    assign rd_entry = (count_q != 2'd0) ? mem_q[rd_ptr_q] : '0;

    // Next-state: flush empties the queue, otherwise push/pop move 1-bit pointers
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = wr_entry;
                wr_ptr_d        = ~wr_ptr_q;
            end
            if (pop) rd_ptr_d = ~rd_ptr_q;
            count_d = count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    // Queue storage and pointers, cleared asynchronously on reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_q    <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC sequencing, RUN/HALT/FAULT control and redirect handling around a 2-entry queue
module instr_fetch_unit
    import rv_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned ROM_WORDS = 4096
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  fetch_en,
    instr_fetch_unit_if.master    bus,
    output logic                  halted,
    output logic                  fault,
    output logic                  misalign_err
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         misalign_q, misalign_d;
    logic [1:0]   count;
    logic         valid, in_rom, can_fetch, push, pop;
    fetch_entry_t wr_entry, head;

    assign valid     = count != 2'd0;
    assign in_rom    = {2'b00, pc_q[31:2]} < ROM_WORDS;
    assign pop       = valid && bus.inst_ready && !bus.redirect_valid;
    assign can_fetch = (state_q == RUN) && fetch_en && !bus.redirect_valid && (count != 2'd2 || pop);
    assign push      = can_fetch && in_rom;
    assign wr_entry  = '{pc: pc_q, instr: bus.rom_data};

    fetch_queue u_queue (
        .clk      (clk),
        .reset_n  (reset_n),
        .push     (push),
        .pop      (pop),
        .flush    (bus.redirect_valid),
        .wr_entry (wr_entry),
        .rd_entry (head),
        .count    (count)
    );

    assign bus.rom_addr   = pc_q;
    assign bus.inst_valid = valid;
    assign bus.inst_out   = head.instr;
    assign bus.inst_pc    = head.pc;
    assign halted         = state_q == HALT;
    assign fault          = state_q == FAULT;
    assign misalign_err   = misalign_q;

    // Redirect wins over everything; otherwise a push advances PC, and an out-of-ROM fetch faults
    always_comb begin
        pc_d       = pc_q;
        state_d    = state_q;
        misalign_d = 1'b0;
        if (bus.redirect_valid) begin
            pc_d       = {bus.redirect_pc[31:2], 2'b00};
            state_d    = RUN;
            misalign_d = |bus.redirect_pc[1:0];
        end else if (push) begin
            pc_d    = pc_q + 32'd4;
            state_d = (bus.rom_data == ECALL_INSTR) ? HALT : state_q;
        end else if (can_fetch) begin
            state_d = FAULT;
        end
    end

    // PC, control state and misalignment pulse registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q       <= RESET_PC;
            state_q    <= RUN;
            misalign_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            state_q    <= state_d;
            misalign_q <= misalign_d;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed checks of fetch flow, stall, redirect, halt, fault and async reset
module tb_instr_fetch_unit;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic fetch_en = 1'b1;
    logic halted, fault, misalign_err;
    int   checks = 0;
    int   errors = 0;
    logic [31:0] rom [0:4095];

    instr_fetch_unit_if bus ();

    instr_fetch_unit #(.RESET_PC(32'h0), .ROM_WORDS(4096)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .fetch_en     (fetch_en),
        .bus          (bus),
        .halted       (halted),
        .fault        (fault),
        .misalign_err (misalign_err)
    );

    always #5 clk = ~clk;

    assign bus.rom_data = rom[bus.rom_addr[13:2]];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic ready);
        reset_n            = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.inst_ready     = ready;
        tick();
        reset_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) rom[i] = 32'h0000_0013 | (32'(i) << 20);
        rom[0] = 32'h0000_12b7;
        rom[1] = 32'h0000_0317;
        rom[2] = 32'h0080_006f;
        rom[3] = 32'h0000_8067;
        bus.inst_ready     = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        #2;
        chk("rst_valid", {31'b0, bus.inst_valid}, 32'd0);
        chk("rst_halted", {31'b0, halted}, 32'd0);
        chk("rst_fault", {31'b0, fault}, 32'd0);
        chk("rst_misalign", {31'b0, misalign_err}, 32'd0);
        chk("rst_addr", bus.rom_addr, 32'h0);
        chk("rst_out", bus.inst_out, 32'h0);
        // straight-line fetch with ready held high
        do_reset(1'b1);
        chk("rel_valid", {31'b0, bus.inst_valid}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("seq_valid", {31'b0, bus.inst_valid}, 32'd1);
            chk("seq_pc", bus.inst_pc, 32'(4 * k));
            chk("seq_out", bus.inst_out, rom[k]);
        end
        chk("seq_addr", bus.rom_addr, 32'd16);
        // backpressure: queue fills, PC stalls, then drains in order
        do_reset(1'b0);
        repeat (5) tick();
        chk("stall_addr", bus.rom_addr, 32'd8);
        chk("stall_pc", bus.inst_pc, 32'd0);
        chk("stall_out", bus.inst_out, rom[0]);
        bus.inst_ready = 1'b1;
        chk("drain_pc0", bus.inst_pc, 32'd0);
        tick();
        chk("drain_pc1", bus.inst_pc, 32'd4);
        tick();
        chk("drain_pc2", bus.inst_pc, 32'd8);
        tick();
        chk("drain_pc3", bus.inst_pc, 32'd12);
        // redirect while full flushes the stale entries
        do_reset(1'b0);
        repeat (3) tick();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h40;
        bus.inst_ready     = 1'b1;
        tick();
        bus.redirect_valid = 1'b0;
        chk("redir_valid", {31'b0, bus.inst_valid}, 32'd0);
        chk("redir_addr", bus.rom_addr, 32'h40);
        tick();
        chk("redir_pc", bus.inst_pc, 32'h40);
        chk("redir_out", bus.inst_out, rom[16]);
        // ECALL halts fetch after it is queued
        rom[2] = 32'h0000_0073;
        do_reset(1'b1);
        tick();
        tick();
        chk("halt_pc4", bus.inst_pc, 32'd4);
        chk("halt_pre", {31'b0, halted}, 32'd0);
        tick();
        chk("halt_pc8", bus.inst_pc, 32'd8);
        chk("halt_out", bus.inst_out, 32'h73);
        chk("halt_set", {31'b0, halted}, 32'd1);
        tick();
        chk("halt_empty", {31'b0, bus.inst_valid}, 32'd0);
        chk("halt_addr", bus.rom_addr, 32'd12);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0;
        tick();
        bus.redirect_valid = 1'b0;
        chk("halt_clr", {31'b0, halted}, 32'd0);
        chk("halt_misalign", {31'b0, misalign_err}, 32'd0);
        tick();
        chk("resume_pc", bus.inst_pc, 32'd0);
        rom[2] = 32'h0080_006f;
        // misaligned redirect near the top of ROM, then fault past it
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_3FFE;
        tick();
        bus.redirect_valid = 1'b0;
        chk("mis_pulse", {31'b0, misalign_err}, 32'd1);
        chk("mis_addr", bus.rom_addr, 32'h3FFC);
        tick();
        chk("mis_drop", {31'b0, misalign_err}, 32'd0);
        chk("mis_pc", bus.inst_pc, 32'h3FFC);
        chk("mis_out", bus.inst_out, rom[4095]);
        chk("end_addr", bus.rom_addr, 32'h4000);
        chk("fault_pre", {31'b0, fault}, 32'd0);
        tick();
        chk("fault_set", {31'b0, fault}, 32'd1);
        chk("fault_empty", {31'b0, bus.inst_valid}, 32'd0);
        chk("fault_hold", bus.rom_addr, 32'h4000);
        tick();
        chk("fault_stay", {31'b0, bus.inst_valid}, 32'd0);
        // asynchronous reset mid-cycle with a full queue
        do_reset(1'b0);
        repeat (3) tick();
        chk("ar_full", {31'b0, bus.inst_valid}, 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("ar_valid", {31'b0, bus.inst_valid}, 32'd0);
        chk("ar_addr", bus.rom_addr, 32'h0);
        tick();
        reset_n        = 1'b1;
        bus.inst_ready = 1'b1;
        tick();
        chk("ar_pc", bus.inst_pc, 32'h0);
        chk("ar_out", bus.inst_out, rom[0]);
        tick();
        chk("ar_pc4", bus.inst_pc, 32'd4);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter RESET_PC, 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter ROM_WORDS, 4096, number of 32-bit instruction words addressable in instruction ROM.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 fetch_en  input  1  permits fetching; pops remain allowed when low.
REQ-006 rom_addr  output  32  byte address to instruction ROM (combinational ROM, word-indexed by addr[31:2]).
REQ-007 rom_data  input  32  instruction word returned by ROM in the same cycle.
REQ-008 inst_valid  output  1  head queue entry is valid.
REQ-009 inst_ready  input  1  downstream decode/control accepts head entry.
REQ-010 inst_out  output  32  head entry instruction.
REQ-011 inst_pc  output  32  head entry PC.
REQ-012 redirect_valid  input  1  branch/jump/trap redirect request.
REQ-013 redirect_pc  input  32  redirect target byte address.
REQ-014 halted  output  1  unit in HALT state (ECALL fetched).
REQ-015 fault  output  1  unit in FAULT state (PC outside ROM).
REQ-016 misalign_err  output  1  one-cycle pulse: redirect_pc[1:0] nonzero.

Function
REQ-017 rom_addr SHALL equal pc_q combinationally at all times.
REQ-018 Unit SHALL hold a 2-entry FIFO of {pc, instr}; inst_valid = (count != 0); inst_out/inst_pc driven from head entry, zero when empty.
REQ-019 Pop SHALL occur when inst_valid && inst_ready && !redirect_valid.
REQ-020 Push SHALL occur when state RUN, fetch_en=1, redirect_valid=0, pc_q[31:2] < ROM_WORDS, and (count<2 or pop same cycle); pushed entry = {pc_q, rom_data}; pc_q <= pc_q + 4.
REQ-021 Latency: instruction at pc_q SHALL appear on inst_out the cycle after its push edge; back-to-back throughput one instruction/cycle with inst_ready held high.
REQ-022 Simultaneous push and pop SHALL leave count unchanged; full queue without pop SHALL stall PC.
REQ-023 FIFO read/write pointers SHALL be 1 bit, wrapping modulo 2; count range 0..2.
REQ-024 States RUN, HALT, FAULT; RUN->HALT when pushed rom_data equals 32'h0000_0073 (ECALL), entry still pushed, pc_q advances to ECALL pc+4.
REQ-025 RUN->FAULT when push conditions hold except pc_q[31:2] >= ROM_WORDS; no push, pc_q held.
REQ-026 HALT and FAULT SHALL not push; queued entries SHALL still drain via pops.
REQ-027 redirect_valid SHALL have highest priority: queue flushed (count=0), pc_q <= {redirect_pc[31:2], 2'b00}, state <= RUN, no push or pop that cycle, from any state.
REQ-028 misalign_err SHALL pulse for the cycle after a redirect with redirect_pc[1:0] != 0.
REQ-029 halted = (state==HALT); fault = (state==FAULT); both registered-state decoded.
REQ-030 pc_q arithmetic SHALL be 32-bit modulo 2^32.

Reset
REQ-031 reset_n low SHALL immediately force pc_q=RESET_PC, count=0, pointers=0, state=RUN, misalign_err=0; thus inst_valid=0, halted=0, fault=0.
REQ-032 Reset asserted mid-fetch SHALL discard all queued entries; first push after release uses RESET_PC.

Structure
REQ-033 Package rv_fetch_pkg SHALL hold fetch_state_e enum (RUN, HALT, FAULT), fetch_entry_t struct {pc, instr}, and constant ECALL_INSTR = 32'h0000_0073.
REQ-034 One sub-module fetch_queue (2-entry FIFO of fetch_entry_t with push/pop/flush, count, async active-low reset) SHALL be instantiated; state machine and PC stay in instr_fetch_unit.

Verification
REQ-035 Reset release, ROM words 0..3 = LUI/AUIPC/JAL/JALR, inst_ready=1 -> inst_pc 0,4,8,12 on consecutive cycles with matching inst_out, first valid one cycle after release.
REQ-036 inst_ready=0 for 5 cycles -> count reaches 2, pc_q stalls at 8, inst_out holds PC 0 entry; ready=1 -> entries 0,4,8 in order, none lost or duplicated.
REQ-037 Redirect to 32'h40 while queue full -> next cycle inst_valid=0, then inst_pc=32'h40; stale PCs 0/4 never appear.
REQ-038 ROM word 2 = 32'h0000_0073 -> entries 0,4,8 delivered, halted=1, no PC 12 entry; redirect to 0 -> halted=0, fetch resumes at 0.
REQ-039 Redirect to 32'h0000_3FFE with ROM_WORDS=4096 -> misalign_err pulse, pc_q=32'h3FFC fetched, then 32'h4000 -> fault=1, no push.
REQ-040 reset_n asserted asynchronously mid-cycle with 2 entries queued -> inst_valid falls before next clk edge; after release fetch restarts at RESET_PC.
